// File: rtl/vc_types_pkg.sv
// vc_types_pkg: victim-cache eviction geometry and FSM state type
package vc_types_pkg;
    localparam int s_offset   = 5;
    localparam int s_line     = 8 * (2 ** s_offset);
    localparam int burst_size = 64;
    localparam int size_of_vc = 8;
    localparam int s_vtag     = 32 - s_offset;
    localparam int NBEATS     = s_line / burst_size;
    localparam int CNT_W      = $clog2(NBEATS);
    typedef enum logic [1:0] {IDLE, BURST, DONE} evict_state_t;
endpackage

// File: rtl/vc_sel_encoder.sv
// vc_sel_encoder: one-hot select to index, lowest set bit wins; valid = any bit set
// Ports: sel (one-hot/multi-hot select), idx (index of lowest set bit), valid (sel != 0)
module vc_sel_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] sel,
    output logic [W-1:0] idx,
    output logic         valid
);
    // Scan downwards so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (sel[i]) idx = W'(i);
    end
    assign valid = |sel;
endmodule

// File: rtl/vc_evict_writer.sv
// vc_evict_writer: latches one victim-cache line and writes it to pmem as a beat burst
// Ports: clk, rst (async active-low); cacheline1..8 data-store lines; evict_req/sel/tag request;
//        evict_ready (idle), evict_done/evict_err one-cycle pulses; mem_write/address/wdata burst
//        outputs; mem_resp beat acknowledge.
module vc_evict_writer
    import vc_types_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [s_line-1:0]     cacheline1,
    input  logic [s_line-1:0]     cacheline2,
    input  logic [s_line-1:0]     cacheline3,
    input  logic [s_line-1:0]     cacheline4,
    input  logic [s_line-1:0]     cacheline5,
    input  logic [s_line-1:0]     cacheline6,
    input  logic [s_line-1:0]     cacheline7,
    input  logic [s_line-1:0]     cacheline8,
    input  logic                  evict_req,
    input  logic [size_of_vc-1:0] evict_sel,
    input  logic [s_vtag-1:0]     evict_tag,
    output logic                  evict_ready,
    output logic                  evict_done,
    output logic                  evict_err,
    output logic                  mem_write,
    output logic [31:0]           mem_address,
    output logic [burst_size-1:0] mem_wdata,
    input  logic                  mem_resp
);
    logic [s_line-1:0]             lines [size_of_vc];
    logic [$clog2(size_of_vc)-1:0] sel_idx;
    logic                          sel_valid;
    evict_state_t                  state;
    logic [CNT_W-1:0]              cnt;
    logic [s_line-1:0]             line_q;
    logic [31:0]                   addr_q;
    logic                          last;

    assign lines = '{cacheline1, cacheline2, cacheline3, cacheline4,
                     cacheline5, cacheline6, cacheline7, cacheline8};

    vc_sel_encoder #(.N(size_of_vc)) u_enc (
        .sel   (evict_sel),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    assign last = cnt == CNT_W'(NBEATS - 1);

    // The line is captured on accept so the data store may refill the slot mid-burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            evict_done <= 1'b0;
            evict_err  <= 1'b0;
        end else begin
            evict_done <= 1'b0;
            evict_err  <= 1'b0;
            case (state)
                IDLE: if (evict_req) begin
                    if (!sel_valid) evict_err <= 1'b1;
                    else begin
                        line_q <= lines[sel_idx];
                        addr_q <= {evict_tag, {s_offset{1'b0}}};
                        cnt    <= '0;
                        state  <= BURST;
                    end
                end
                BURST: if (mem_resp) begin
                    if (last) begin
                        state      <= DONE;
                        evict_done <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign evict_ready = state == IDLE;
    assign mem_write   = state == BURST;
    assign mem_address = addr_q;
    assign mem_wdata   = line_q[cnt*burst_size +: burst_size];
endmodule

// File: tb/tb_vc_evict_writer.sv
// tb_vc_evict_writer: directed and randomized eviction bursts checked against a line-snapshot model
module tb_vc_evict_writer;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] cl [8];
    logic         evict_req = 1'b0;
    logic [7:0]   evict_sel = '0;
    logic [26:0]  evict_tag = '0;
    logic         evict_ready, evict_done, evict_err, mem_write;
    logic [31:0]  mem_address;
    logic [63:0]  mem_wdata;
    logic         mem_resp = 1'b0;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    vc_evict_writer dut (
        .clk(clk), .rst(rst),
        .cacheline1(cl[0]), .cacheline2(cl[1]), .cacheline3(cl[2]), .cacheline4(cl[3]),
        .cacheline5(cl[4]), .cacheline6(cl[5]), .cacheline7(cl[6]), .cacheline8(cl[7]),
        .evict_req(evict_req), .evict_sel(evict_sel), .evict_tag(evict_tag),
        .evict_ready(evict_ready), .evict_done(evict_done), .evict_err(evict_err),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk_idle();
        chk("ready", 256'(evict_ready), 256'(1));
        chk("idle_wr", 256'(mem_write), 256'(0));
        chk("idle_done", 256'(evict_done), 256'(0));
    endtask

    // One eviction from IDLE. sb/sn: stall sn cycles on beat sb; rnd: random stalls and
    // request noise during the burst; rb: assert reset in the first cycle of beat rb.
    task automatic evict(input logic [7:0] sel, input logic [26:0] tag, input int sb,
                         input int sn, input bit rnd, input int rb);
        logic [255:0] snap;
        int idx, s;
        chk_idle();
        evict_req = 1'b1;
        evict_sel = sel;
        evict_tag = tag;
        mem_resp  = 1'($urandom_range(0, 1));
        idx = -1;
        for (int i = 7; i >= 0; i--) if (sel[i]) idx = i;
        snap = (idx >= 0) ? cl[idx] : '0;
        tick();
        evict_req = 1'b0;
        if (idx < 0) begin
            chk("err_pulse", 256'(evict_err), 256'(1));
            chk("err_ready", 256'(evict_ready), 256'(1));
            chk("err_wr", 256'(mem_write), 256'(0));
            tick();
            chk("err_clear", 256'(evict_err), 256'(0));
            chk("err_wr2", 256'(mem_write), 256'(0));
            return;
        end
        cl[idx] = rand256();
        for (int k = 0; k < 4; k++) begin
            s = rnd ? $urandom_range(0, 2) : (k == sb ? sn : 0);
            for (int j = 0; j <= s; j++) begin
                mem_resp = (j == s);
                if (rnd) begin
                    evict_req = 1'($urandom_range(0, 1));
                    evict_sel = 8'($urandom);
                    evict_tag = 27'($urandom);
                end
                chk("burst_wr", 256'(mem_write), 256'(1));
                chk("burst_ready", 256'(evict_ready), 256'(0));
                chk("addr", 256'(mem_address), 256'({tag, 5'b0}));
                chk("wdata", 256'(mem_wdata), 256'(snap[k*64 +: 64]));
                chk("burst_done", 256'(evict_done), 256'(0));
                chk("burst_err", 256'(evict_err), 256'(0));
                if (k == rb && j == 0) begin
                    #2 rst = 1'b0;
                    #1;
                    chk("rst_wr", 256'(mem_write), 256'(0));
                    chk("rst_done", 256'(evict_done), 256'(0));
                    chk("rst_addr", 256'(mem_address), 256'(0));
                    chk("rst_wdata", 256'(mem_wdata), 256'(0));
                    #2 rst = 1'b1;
                    mem_resp  = 1'b0;
                    evict_req = 1'b0;
                    tick();
                    chk_idle();
                    return;
                end
                tick();
            end
        end
        evict_req = 1'b0;
        mem_resp  = 1'($urandom_range(0, 1));
        chk("done_pulse", 256'(evict_done), 256'(1));
        chk("done_wr", 256'(mem_write), 256'(0));
        chk("done_ready", 256'(evict_ready), 256'(0));
        tick();
        chk("done_clear", 256'(evict_done), 256'(0));
        chk("post_ready", 256'(evict_ready), 256'(1));
    endtask

    initial begin
        logic [7:0] rs;
        for (int i = 0; i < 8; i++) cl[i] = rand256();
        #2;
        chk("rst_ready", 256'(evict_ready), 256'(1));
        chk("rst_done0", 256'(evict_done), 256'(0));
        chk("rst_err0", 256'(evict_err), 256'(0));
        chk("rst_wr0", 256'(mem_write), 256'(0));
        chk("rst_addr0", 256'(mem_address), 256'(0));
        chk("rst_wdata0", 256'(mem_wdata), 256'(0));
        #10 rst = 1'b1;
        tick();
        cl[2] = {64'hD3D3D3D3D3D3D3D3, 64'hC3C3C3C3C3C3C3C3,
                 64'hB3B3B3B3B3B3B3B3, 64'hA3A3A3A3A3A3A3A3};
        evict(8'h04, 27'h1, -1, 0, 1'b0, -1);
        evict(8'h10, 27'h5A5A5A5, 1, 3, 1'b0, -1);
        evict(8'h00, 27'h123, -1, 0, 1'b0, -1);
        evict(8'h81, 27'h7FFFFFF, -1, 0, 1'b0, -1);
        evict(8'h02, 27'h0ABCDEF, -1, 0, 1'b1, -1);
        evict(8'h40, 27'h0000777, -1, 0, 1'b0, -1);
        evict(8'h08, 27'h3333333, -1, 0, 1'b0, 2);
        evict(8'h20, 27'h4444444, 0, 2, 1'b0, -1);
        for (int t = 0; t < 60; t++) begin
            rs = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            evict(rs, 27'($urandom), -1, 0, 1'b1, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
